// File: rtl/gb_bus_pkg.sv
// gb_bus_pkg: shared bus constants and OAM DMA state encoding (PAD states only with DMA_CYCLE_ACCURATE_EN)
package gb_bus_pkg;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_LEN_DEF  = 160;
`ifdef DMA_CYCLE_ACCURATE_EN
    typedef enum logic [2:0] {IDLE, START, READ, WRITE, PAD0, PAD1} dma_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, READ, WRITE} dma_state_t;
`endif
endpackage

// File: rtl/memory_oam_dma.sv
// memory_oam_dma: OAM DMA bus initiator copying OAM_LEN bytes from {src,idx} to FE00+idx; DMA_CYCLE_ACCURATE_EN adds 4-clock bytes and a 4-clock START
module memory_oam_dma
    import gb_bus_pkg::*;
#(
    parameter int OAM_LEN = OAM_LEN_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_nwrite,
    output logic [7:0]  dma_reg,
    output logic        busy,
    output logic        bus_request,
    input  logic        bus_grant,
    output wire  [15:0] address_bus,
    inout  wire  [7:0]  data_bus,
    output wire         nread,
    output wire         nwrite
);
    dma_state_t  state_q, state_d;
    logic [7:0]  dma_reg_q, dma_reg_d;
    logic [7:0]  src_q, src_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  latch_q, latch_d;
    logic        reg_wr, own, last;
    logic [15:0] addr;
    logic        rd_n, wr_n;
`ifdef DMA_CYCLE_ACCURATE_EN
    logic [1:0]  pad_q, pad_d;
`endif

    assign reg_wr      = (cpu_address == DMA_REG_ADDR) && !cpu_nwrite;
    assign own         = (state_q != IDLE) && bus_grant;
    assign last        = index_q == 8'(OAM_LEN - 1);
    assign busy        = state_q != IDLE;
    assign bus_request = state_q != IDLE;
    assign dma_reg     = dma_reg_q;

    // Next state: a register write restarts from any state; otherwise advance only while granted
    always_comb begin
        state_d   = state_q;
        dma_reg_d = dma_reg_q;
        src_d     = src_q;
        index_d   = index_q;
        latch_d   = latch_q;
`ifdef DMA_CYCLE_ACCURATE_EN
        pad_d     = pad_q;
`endif
        if (reg_wr) begin
            dma_reg_d = cpu_data;
            src_d     = cpu_data;
            index_d   = 8'h00;
            state_d   = START;
`ifdef DMA_CYCLE_ACCURATE_EN
            pad_d     = 2'd0;
`endif
        end else if (own) begin
            case (state_q)
`ifdef DMA_CYCLE_ACCURATE_EN
                START: begin
                    pad_d   = pad_q + 2'd1;
                    state_d = (pad_q == 2'd3) ? READ : START;
                end
                READ: begin
                    state_d = WRITE;
                    latch_d = data_bus;
                end
                WRITE: state_d = PAD0;
                PAD0:  state_d = PAD1;
                PAD1: begin
                    state_d = last ? IDLE : READ;
                    index_d = last ? index_q : index_q + 8'd1;
                end
`else
                START: state_d = READ;
                READ: begin
                    state_d = WRITE;
                    latch_d = data_bus;
                end
                WRITE: begin
                    state_d = last ? IDLE : READ;
                    index_d = last ? index_q : index_q + 8'd1;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // Bus values per state; START owns the bus without using it, PAD holds the write address
    always_comb begin
        addr = (state_q == READ) ? {src_q, index_q} :
               (state_q == IDLE || state_q == START) ? 16'h0000 : OAM_BASE + {8'h00, index_q};
        rd_n = state_q != READ;
        wr_n = state_q != WRITE;
    end

    assign address_bus = own ? addr : 16'hzzzz;
    assign nread       = own ? rd_n : 1'bz;
    assign nwrite      = own ? wr_n : 1'bz;
    assign data_bus    = (own && state_q == WRITE) ? latch_q : 8'hzz;

    // State registers; reset aborts any transfer immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dma_reg_q <= 8'h00;
            src_q     <= 8'h00;
            index_q   <= 8'h00;
            latch_q   <= 8'h00;
`ifdef DMA_CYCLE_ACCURATE_EN
            pad_q     <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            dma_reg_q <= dma_reg_d;
            src_q     <= src_d;
            index_q   <= index_d;
            latch_q   <= latch_d;
`ifdef DMA_CYCLE_ACCURATE_EN
            pad_q     <= pad_d;
`endif
        end
    end
endmodule

// File: tb/tb_memory_oam_dma.sv
// tb_memory_oam_dma: randomized self-checking bench with a WRAM/OAM responder model and pulled-up bus lines
module tb_memory_oam_dma;
`ifdef DMA_CYCLE_ACCURATE_EN
    localparam int LAT = 644;
`else
    localparam int LAT = 321;
`endif
    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data;
    logic        cpu_nwrite;
    logic        bus_grant;
    logic [7:0]  dma_reg;
    logic        busy;
    logic        bus_request;
    wire  [15:0] address_bus;
    wire  [7:0]  data_bus;
    wire         nread;
    wire         nwrite;

    logic [7:0]  wram [0:65535];
    logic [7:0]  oam [0:255];
    logic [7:0]  exp_oam [0:159];
    logic [7:0]  prev_oam [0:159];
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    pullup pu_a (address_bus);
    pullup pu_d (data_bus);
    pullup pu_r (nread);
    pullup pu_w (nwrite);

    memory_oam_dma dut (
        .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_data(cpu_data),
        .cpu_nwrite(cpu_nwrite), .dma_reg(dma_reg), .busy(busy), .bus_request(bus_request),
        .bus_grant(bus_grant), .address_bus(address_bus), .data_bus(data_bus),
        .nread(nread), .nwrite(nwrite)
    );

    // WRAM responder answers any read strobe; OAM responder captures writes to FExx
    assign data_bus = (nread === 1'b0) ? wram[address_bus] : 8'hzz;
    always @(posedge clock) begin
        if (nwrite === 1'b0 && address_bus[15:8] == 8'hFE) begin
            oam[address_bus[7:0]] <= data_bus;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic fill_src(input logic [7:0] s, input bit pattern);
        for (int i = 0; i < 160; i++) begin
            logic [7:0] v;
            v = pattern ? (8'(i) ^ 8'h5A) : 8'($urandom);
            wram[{s, 8'(i)}] = v;
            exp_oam[i] = v;
        end
    endtask

    task automatic start_dma(input logic [7:0] s);
        @(negedge clock);
        cpu_address = 16'hFF46;
        cpu_data    = s;
        cpu_nwrite  = 1'b0;
        @(negedge clock);
        cpu_nwrite  = 1'b1;
        cpu_address = 16'h0000;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cpu_address = 16'h0000;
        cpu_data = 8'h00;
        cpu_nwrite = 1'b1;
        bus_grant = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, bus_request, dma_reg} !== 10'h000) begin
            errors++;
            $display("FAIL reset_regs busy=%b req=%b dma_reg=%h required 0 0 00", busy, bus_request, dma_reg);
        end
        checks++;
        if ({address_bus, data_bus, nread, nwrite} !== {16'hFFFF, 8'hFF, 2'b11}) begin
            errors++;
            $display("FAIL reset_bus addr=%h data=%h nrd=%b nwr=%b required floating", address_bus, data_bus, nread, nwrite);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle;
        int bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clock);
            cpu_address = 16'($urandom_range(0, 16'hFF45));
            cpu_nwrite  = 1'($urandom);
            #1;
            if ({bus_request, busy, address_bus, data_bus, nread, nwrite} !== {2'b00, 16'hFFFF, 8'hFF, 2'b11}) bad++;
        end
        cpu_nwrite = 1'b1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_bus cycles_driven=%0d required 0", bad);
        end
    endtask

    task automatic check_oam(input string tag);
        int bad = 0;
        for (int i = 0; i < 160; i++) if (oam[i] !== exp_oam[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_oam wrong_bytes=%0d required 0 (byte0 %h vs %h)", tag, bad, oam[0], exp_oam[0]);
        end
    endtask

    task automatic test_transfer(input logic [7:0] s, input bit pattern);
        int cnt = 0;
        int strobes = 0;
        fill_src(s, pattern);
        start_dma(s);
        while (busy && cnt < 2000) begin
            cnt++;
            if (nread === 1'b0 || nwrite === 1'b0) strobes++;
            cpu_address = 16'hFF47;
            cpu_nwrite  = 1'($urandom);
            @(negedge clock);
        end
        cpu_nwrite = 1'b1;
        checks++;
        if (cnt != LAT) begin
            errors++;
            $display("FAIL xfer_busy src=%h busy_clocks=%0d required %0d", s, cnt, LAT);
        end
        checks++;
        if (strobes != 320) begin
            errors++;
            $display("FAIL xfer_strobes src=%h strobe_clocks=%0d required 320", s, strobes);
        end
        checks++;
        if (dma_reg !== s) begin
            errors++;
            $display("FAIL xfer_dma_reg got=%h required %h", dma_reg, s);
        end
        check_oam("xfer");
        for (int i = 0; i < 160; i++) prev_oam[i] = exp_oam[i];
    endtask

    task automatic test_grant_drop(input logic [7:0] s);
        int cnt = 0;
        int floats = 0;
        int w0 = 0;
        bit dropped = 1'b0;
        fill_src(s, 1'b0);
        start_dma(s);
        while (busy && cnt < 3000) begin
            cnt++;
            if (!dropped && nread === 1'b0 && address_bus === {s, 8'd50}) begin
                dropped = 1'b1;
                bus_grant = 1'b0;
                w0 = wr_cnt;
                for (int k = 0; k < 10; k++) begin
                    #1;
                    if ({address_bus, data_bus, nread, nwrite} !== {16'hFFFF, 8'hFF, 2'b11}) floats++;
                    @(negedge clock);
                    cnt++;
                end
                bus_grant = 1'b1;
                #1;
                checks++;
                if (wr_cnt != w0) begin
                    errors++;
                    $display("FAIL drop_writes oam_writes=%0d required 0", wr_cnt - w0);
                end
                checks++;
                if (floats != 0) begin
                    errors++;
                    $display("FAIL drop_float driven_clocks=%0d required 0", floats);
                end
                checks++;
                if ({address_bus, nread} !== {s, 8'd50, 1'b0}) begin
                    errors++;
                    $display("FAIL drop_resume addr=%h nrd=%b required %h 0", address_bus, nread, {s, 8'd50});
                end
            end
            @(negedge clock);
        end
        checks++;
        if (!dropped || cnt != LAT + 10) begin
            errors++;
            $display("FAIL drop_busy dropped=%b busy_clocks=%0d required %0d", dropped, cnt, LAT + 10);
        end
        check_oam("drop");
        for (int i = 0; i < 160; i++) prev_oam[i] = exp_oam[i];
    endtask

    task automatic test_restart(input logic [7:0] s1, input logic [7:0] s2);
        int cnt = 0;
        int guard = 0;
        fill_src(s1, 1'b0);
        start_dma(s1);
        while (!(nwrite === 1'b0 && address_bus === 16'hFE50) && guard < 2000) begin
            guard++;
            @(negedge clock);
        end
        fill_src(s2, 1'b0);
        start_dma(s2);
        checks++;
        if ({busy, address_bus, nread, nwrite} !== {1'b1, 16'h0000, 2'b11}) begin
            errors++;
            $display("FAIL restart_start guard=%0d busy=%b addr=%h required 1 0000", guard, busy, address_bus);
        end
        while (busy && cnt < 2000) begin
            cnt++;
            @(negedge clock);
        end
        checks++;
        if (cnt != LAT) begin
            errors++;
            $display("FAIL restart_busy busy_clocks=%0d required %0d", cnt, LAT);
        end
        checks++;
        if (dma_reg !== s2) begin
            errors++;
            $display("FAIL restart_dma_reg got=%h required %h", dma_reg, s2);
        end
        check_oam("restart");
        for (int i = 0; i < 160; i++) prev_oam[i] = exp_oam[i];
    endtask

    task automatic test_reset_mid(input logic [7:0] s);
        int guard = 0;
        int bad_new = 0;
        int bad_old = 0;
        fill_src(s, 1'b0);
        start_dma(s);
        while (!(nread === 1'b0 && address_bus === {s, 8'd20}) && guard < 2000) begin
            guard++;
            @(negedge clock);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, bus_request, dma_reg} !== 10'h000) begin
            errors++;
            $display("FAIL abort_regs guard=%0d busy=%b req=%b dma_reg=%h required 0 0 00", guard, busy, bus_request, dma_reg);
        end
        checks++;
        if ({address_bus, data_bus, nread, nwrite} !== {16'hFFFF, 8'hFF, 2'b11}) begin
            errors++;
            $display("FAIL abort_bus addr=%h data=%h nrd=%b nwr=%b required floating", address_bus, data_bus, nread, nwrite);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        for (int i = 0; i < 160; i++) begin
            if (i < 20 && oam[i] !== exp_oam[i]) bad_new++;
            if (i >= 20 && oam[i] !== prev_oam[i]) bad_old++;
        end
        checks++;
        if (bad_new != 0 || bad_old != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_oam wrong_low=%0d wrong_high=%0d busy=%b required 0 0 0", bad_new, bad_old, busy);
        end
    endtask

    initial begin
        test_reset;
        test_idle;
        test_transfer(8'hC1, 1'b1);
        for (int n = 0; n < 2; n++) test_transfer(8'($urandom), 1'b0);
        test_grant_drop(8'($urandom));
        test_restart(8'($urandom_range(0, 127)), 8'hD0);
        test_reset_mid(8'($urandom_range(128, 255)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
